// File: rtl/mem_arbiter_pkg.sv
// Shared CPU package: opcode constants plus the memory arbiter state encoding
// and default word size.
package mem_arbiter_pkg;

    localparam int unsigned WORD_SIZE_DEF = 16;
    localparam int unsigned GRANT_CNT_W   = 16;

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_LOAD   = 4'd1,
        OP_STORE  = 4'd2,
        OP_ADD    = 4'd3,
        OP_SUB    = 4'd4,
        OP_AND    = 4'd5,
        OP_OR     = 4'd6,
        OP_BRANCH = 4'd7
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_arb_priority.sv
// I/D priority decision with a starvation counter that lets a waiting fetch in
// after STARVE_LIMIT consecutive data grants.
module arb_priority #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_req,
    input  logic d_req,
    output logic o_grant_i_c,
    output logic o_grant_d_c
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_starved;

    assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

    // D normally wins a tie; a starved fetch overrides it
    always_comb begin
        o_grant_i_c = 1'b0;
        o_grant_d_c = 1'b0;
        if (i_en) begin
            if (d_req && !(i_req && w_starved)) begin
                o_grant_d_c = 1'b1;
            end else if (i_req) begin
                o_grant_i_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (o_grant_i_c) begin
            r_starve_cnt <= '0;
        end else if (o_grant_d_c && i_req && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single shared memory port,
// one outstanding transaction at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = WORD_SIZE_DEF,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_req,
    input  logic [WORD_SIZE-1:0]   i_address,
    output logic [WORD_SIZE-1:0]   i_rdata,
    output logic                   i_ready,
    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [WORD_SIZE-1:0]   d_address,
    input  logic [WORD_SIZE-1:0]   d_wdata,
    output logic [WORD_SIZE-1:0]   d_rdata,
    output logic                   d_ready,
    output logic                   m_req,
    output logic                   m_we,
    output logic [WORD_SIZE-1:0]   m_address,
    output logic [WORD_SIZE-1:0]   m_wdata,
    input  logic [WORD_SIZE-1:0]   m_rdata,
    input  logic                   m_ready,
    output logic [GRANT_CNT_W-1:0] num_i_grant,
    output logic [GRANT_CNT_W-1:0] num_d_grant
);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic                   w_grant_i;
    logic                   w_grant_d;
    logic                   w_done_i;
    logic                   w_done_d;
    logic                   r_m_req;
    logic                   r_m_we;
    logic [WORD_SIZE-1:0]   r_m_address;
    logic [WORD_SIZE-1:0]   r_m_wdata;
    logic [WORD_SIZE-1:0]   r_i_rdata;
    logic [WORD_SIZE-1:0]   r_d_rdata;
    logic                   r_i_ready;
    logic                   r_d_ready;
    logic [GRANT_CNT_W-1:0] r_num_i_grant;
    logic [GRANT_CNT_W-1:0] r_num_d_grant;

    arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk         (clk),
        .reset       (reset),
        .i_en        (r_state == ST_IDLE),
        .i_req       (i_req),
        .d_req       (d_req),
        .o_grant_i_c (w_grant_i),
        .o_grant_d_c (w_grant_d)
    );

    assign w_done_i = (r_state == ST_BUSY_I) && m_ready;
    assign w_done_d = (r_state == ST_BUSY_D) && m_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = ST_BUSY_D;
                end else if (w_grant_i) begin
                    w_state_nxt = ST_BUSY_I;
                end
            end
            ST_BUSY_I: if (m_ready) w_state_nxt = ST_RESP;
            ST_BUSY_D: if (m_ready) w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Winner's request is captured at grant; the memory port runs off these registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_req       <= 1'b0;
            r_m_we        <= 1'b0;
            r_m_address   <= '0;
            r_m_wdata     <= '0;
            r_i_rdata     <= '0;
            r_d_rdata     <= '0;
            r_i_ready     <= 1'b0;
            r_d_ready     <= 1'b0;
            r_num_i_grant <= '0;
            r_num_d_grant <= '0;
        end else begin
            r_i_ready <= w_done_i;
            r_d_ready <= w_done_d;
            if (w_grant_d) begin
                r_m_req       <= 1'b1;
                r_m_we        <= d_we;
                r_m_address   <= d_address;
                r_m_wdata     <= d_wdata;
                r_num_d_grant <= r_num_d_grant + GRANT_CNT_W'(1);
            end else if (w_grant_i) begin
                r_m_req       <= 1'b1;
                r_m_we        <= 1'b0;
                r_m_address   <= i_address;
                r_m_wdata     <= '0;
                r_num_i_grant <= r_num_i_grant + GRANT_CNT_W'(1);
            end else if (w_done_i || w_done_d) begin
                r_m_req <= 1'b0;
                r_m_we  <= 1'b0;
            end
            if (w_done_i) begin
                r_i_rdata <= m_rdata;
            end
            // Stores leave the previous load data visible
            if (w_done_d && !r_m_we) begin
                r_d_rdata <= m_rdata;
            end
        end
    end

    assign m_req       = r_m_req;
    assign m_we        = r_m_we;
    assign m_address   = r_m_address;
    assign m_wdata     = r_m_wdata;
    assign i_rdata     = r_i_rdata;
    assign d_rdata     = r_d_rdata;
    assign i_ready     = r_i_ready;
    assign d_ready     = r_d_ready;
    assign num_i_grant = r_num_i_grant;
    assign num_d_grant = r_num_d_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for single transactions plus
// hand-written sequences for starvation, reset abandon and counter wrap.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [15:0] i_address;
    logic [15:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_address;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ready;
    logic        m_req;
    logic        m_we;
    logic [15:0] m_address;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic        m_ready;
    logic [15:0] num_i_grant;
    logic [15:0] num_d_grant;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .WORD_SIZE    (16),
        .STARVE_LIMIT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req       (i_req),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_ready     (i_ready),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_ready     (d_ready),
        .m_req       (m_req),
        .m_we        (m_we),
        .m_address   (m_address),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .m_ready     (m_ready),
        .num_i_grant (num_i_grant),
        .num_d_grant (num_d_grant)
    );

    typedef struct {
        logic        ireq;
        logic [15:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [15:0] daddr;
        logic [15:0] dwdata;
        logic        mrdy;
        logic [15:0] mrdata;
        logic        e_mreq;
        logic        e_mwe;
        logic [15:0] e_maddr;
        logic [15:0] e_mwdata;
        logic        e_irdy;
        logic        e_drdy;
        logic [15:0] e_irdata;
        logic [15:0] e_drdata;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic ireq, logic [15:0] iaddr, logic dreq, logic dwe,
                                logic [15:0] daddr, logic [15:0] dwdata, logic mrdy,
                                logic [15:0] mrdata, logic e_mreq, logic e_mwe,
                                logic [15:0] e_maddr, logic [15:0] e_mwdata, logic e_irdy,
                                logic e_drdy, logic [15:0] e_irdata, logic [15:0] e_drdata);
        vec_t v;
        v.ireq = ireq;     v.iaddr = iaddr;       v.dreq = dreq;       v.dwe = dwe;
        v.daddr = daddr;   v.dwdata = dwdata;     v.mrdy = mrdy;       v.mrdata = mrdata;
        v.e_mreq = e_mreq; v.e_mwe = e_mwe;       v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
        v.e_irdy = e_irdy; v.e_drdy = e_drdy;     v.e_irdata = e_irdata; v.e_drdata = e_drdata;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        i_req = 1'b0; i_address = '0; d_req = 1'b0; d_we = 1'b0;
        d_address = '0; d_wdata = '0; m_rdata = '0; m_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string tag;
        int    waited;
        logic  exp_i;

        //        ireq iaddr    dreq we daddr    dwdata   mrdy mrdata  | mreq mwe maddr    mwdata   irdy drdy irdata   drdata
        vecs[0]  = mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        vecs[1]  = mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 0, 0, 16'h0010, 16'h0000, 1, 0, 16'h1234, 16'h0000);
        vecs[2]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0010, 16'h0000, 0, 0, 16'h1234, 16'h0000);
        vecs[3]  = mk(1, 16'h0030, 1, 1, 16'h0020, 16'hBEEF, 0, 16'h0000, 1, 1, 16'h0020, 16'hBEEF, 0, 0, 16'h1234, 16'h0000);
        vecs[4]  = mk(1, 16'h0030, 1, 1, 16'h0020, 16'hBEEF, 1, 16'h5555, 0, 0, 16'h0020, 16'hBEEF, 0, 1, 16'h1234, 16'h0000);
        vecs[5]  = mk(1, 16'h0030, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0020, 16'hBEEF, 0, 0, 16'h1234, 16'h0000);
        vecs[6]  = mk(1, 16'h0030, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0030, 16'h0000, 0, 0, 16'h1234, 16'h0000);
        vecs[7]  = mk(1, 16'h0030, 0, 0, 16'h0000, 16'h0000, 1, 16'hA5A5, 0, 0, 16'h0030, 16'h0000, 1, 0, 16'hA5A5, 16'h0000);
        vecs[8]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0030, 16'h0000, 0, 0, 16'hA5A5, 16'h0000);
        vecs[9]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'hFFFF, 0, 0, 16'h0030, 16'h0000, 0, 0, 16'hA5A5, 16'h0000);
        vecs[10] = mk(0, 16'h0000, 1, 0, 16'h0040, 16'h1111, 0, 16'h0000, 1, 0, 16'h0040, 16'h1111, 0, 0, 16'hA5A5, 16'h0000);
        vecs[11] = mk(0, 16'h0000, 1, 0, 16'h0040, 16'h1111, 0, 16'h0000, 1, 0, 16'h0040, 16'h1111, 0, 0, 16'hA5A5, 16'h0000);
        vecs[12] = mk(0, 16'h0000, 1, 0, 16'h0040, 16'h1111, 0, 16'h0000, 1, 0, 16'h0040, 16'h1111, 0, 0, 16'hA5A5, 16'h0000);
        vecs[13] = mk(0, 16'h0000, 1, 0, 16'h0040, 16'h1111, 0, 16'h0000, 1, 0, 16'h0040, 16'h1111, 0, 0, 16'hA5A5, 16'h0000);
        vecs[14] = mk(0, 16'h0000, 1, 0, 16'h0040, 16'h1111, 1, 16'h0BAD, 0, 0, 16'h0040, 16'h1111, 0, 1, 16'hA5A5, 16'h0BAD);
        vecs[15] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'hDEAD, 0, 0, 16'h0040, 16'h1111, 0, 0, 16'hA5A5, 16'h0BAD);

        // Reset state
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        chk("rst_m_req", 32'(m_req), 32'h0);
        chk("rst_m_we", 32'(m_we), 32'h0);
        chk("rst_m_address", 32'(m_address), 32'h0);
        chk("rst_ready", 32'({i_ready, d_ready}), 32'h0);
        chk("rst_rdata", 32'({i_rdata, d_rdata}), 32'h0);
        chk("rst_counters", 32'({num_i_grant, num_d_grant}), 32'h0);
        reset = 1'b0;

        // Table: fetch, store-vs-fetch tie, spurious m_ready, load with 3 waits
        for (int k = 0; k < 16; k++) begin
            i_req = vecs[k].ireq;     i_address = vecs[k].iaddr;
            d_req = vecs[k].dreq;     d_we = vecs[k].dwe;
            d_address = vecs[k].daddr; d_wdata = vecs[k].dwdata;
            m_ready = vecs[k].mrdy;   m_rdata = vecs[k].mrdata;
            step();
            tag = $sformatf("vec%0d", k);
            chk({tag, "_m_req"}, 32'(m_req), 32'(vecs[k].e_mreq));
            chk({tag, "_m_we"}, 32'(m_we), 32'(vecs[k].e_mwe));
            chk({tag, "_m_address"}, 32'(m_address), 32'(vecs[k].e_maddr));
            chk({tag, "_m_wdata"}, 32'(m_wdata), 32'(vecs[k].e_mwdata));
            chk({tag, "_i_ready"}, 32'(i_ready), 32'(vecs[k].e_irdy));
            chk({tag, "_d_ready"}, 32'(d_ready), 32'(vecs[k].e_drdy));
            chk({tag, "_i_rdata"}, 32'(i_rdata), 32'(vecs[k].e_irdata));
            chk({tag, "_d_rdata"}, 32'(d_rdata), 32'(vecs[k].e_drdata));
        end
        chk("tbl_num_i_grant", 32'(num_i_grant), 32'd2);
        chk("tbl_num_d_grant", 32'(num_d_grant), 32'd2);

        // Starvation: both requests held, expect D,D,D,D,I,D
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        i_req = 1'b1; i_address = 16'h0100;
        d_req = 1'b1; d_we = 1'b0; d_address = 16'h0200;
        for (int g = 0; g < 6; g++) begin
            waited = 0;
            do begin
                step();
                waited++;
            end while (m_req !== 1'b1 && waited < 10);
            chk($sformatf("starve_grant%0d_m_req", g), 32'(m_req), 32'h1);
            exp_i = (g == 4);
            chk($sformatf("starve_grant%0d_is_i", g), 32'(m_address == 16'h0100), 32'(exp_i));
            if (g == 4) begin
                chk("starve_num_d_at_i", 32'(num_d_grant), 32'd4);
                chk("starve_num_i_at_i", 32'(num_i_grant), 32'd1);
            end
            m_ready = 1'b1; m_rdata = 16'(g);
            step();
            m_ready = 1'b0;
        end
        idle_inputs();
        step();
        step();

        // Reset while BUSY_D, then a late m_ready
        reset = 1'b1;
        step();
        reset = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_address = 16'h0300;
        step();
        chk("rbusy_m_req", 32'(m_req), 32'h1);
        chk("rbusy_num_d", 32'(num_d_grant), 32'd1);
        reset = 1'b1; d_req = 1'b0;
        step();
        chk("rbusy_after_m_req", 32'(m_req), 32'h0);
        chk("rbusy_after_m_address", 32'(m_address), 32'h0);
        chk("rbusy_after_counters", 32'({num_i_grant, num_d_grant}), 32'h0);
        reset = 1'b0; m_ready = 1'b1; m_rdata = 16'h7777;
        step();
        chk("rbusy_late_d_ready", 32'(d_ready), 32'h0);
        chk("rbusy_late_d_rdata", 32'(d_rdata), 32'h0);
        m_ready = 1'b0;
        step();
        chk("rbusy_late2_d_ready", 32'(d_ready), 32'h0);
        i_req = 1'b1; i_address = 16'h0400;
        step();
        chk("rbusy_idle_grant", 32'(m_req), 32'h1);
        chk("rbusy_idle_addr", 32'(m_address), 32'h0400);
        m_ready = 1'b1; m_rdata = 16'h4444;
        step();
        chk("rbusy_i_ready", 32'(i_ready), 32'h1);
        idle_inputs();
        step();

        // Counter wrap: preload 0xFFFF, one more D grant rolls to 0
        force dut.r_num_d_grant = 16'hFFFF;
        step();
        release dut.r_num_d_grant;
        chk("wrap_preload", 32'(num_d_grant), 32'hFFFF);
        d_req = 1'b1; d_we = 1'b1; d_address = 16'h0500; d_wdata = 16'h5A5A;
        step();
        chk("wrap_num_d", 32'(num_d_grant), 32'h0000);
        m_ready = 1'b1;
        step();
        chk("wrap_d_ready", 32'(d_ready), 32'h1);
        idle_inputs();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
